// File: rtl/reg_wb_arb_pkg.sv
// Shared CPU definitions for the register write-back arbiter: register/data widths,
// the hard-wired zero register and the request-port identifiers.
package reg_wb_arb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_L = 1'b1
    } port_e;

    // Writes to the zero register are architecturally discarded.
    function automatic logic is_live_reg(input logic [REG_AW-1:0] addr);
        return (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_wb_arb_wb_fifo.sv
// Write-back FIFO: pointer/occupancy tracking plus an age-ordered view of all
// entries (index 0 = head) so the arbiter can answer hazard queries.
module wb_fifo
    import reg_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_push,
    input  logic [REG_AW-1:0]              i_addr,
    input  logic [REG_DW-1:0]              i_data,
    input  logic                           i_pop,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [DEPTH-1:0]               o_ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]   o_ent_addr,
    output logic [DEPTH-1:0][REG_DW-1:0]   o_ent_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_AW-1:0] r_mem_addr [DEPTH];
    logic [REG_DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload storage; validity is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_addr[r_wr_ptr] <= i_addr;
            r_mem_data[r_wr_ptr] <= i_data;
        end
    end

    // Rotate storage into oldest-first order for the hazard lookup.
    always_comb begin
        o_ent_valid = '0;
        o_ent_addr  = '0;
        o_ent_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_valid[i] = (CW'(i) < r_count);
            o_ent_addr[i]  = r_mem_addr[r_rd_ptr + PW'(i)];
            o_ent_data[i]  = r_mem_data[r_rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/reg_wb_arb.sv
// Register-file write-back arbiter: round-robin between the ALU and long-latency
// pipes into a small FIFO that drains one write per cycle and answers hazard queries.
module reg_wb_arb
    import reg_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_addr,
    input  logic [REG_DW-1:0] a_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [REG_AW-1:0] l_addr,
    input  logic [REG_DW-1:0] l_data,
    input  logic              wb_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_DW-1:0] rf_wdata,
    input  logic [REG_AW-1:0] q_raddr1,
    input  logic [REG_AW-1:0] q_raddr2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [REG_DW-1:0] q_data1,
    output logic [REG_DW-1:0] q_data2
);

    port_e                         r_last;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_pop;
    logic                          w_space;
    logic                          w_grant_a;
    logic                          w_grant_l;
    logic                          w_push;
    logic [REG_AW-1:0]             w_push_addr;
    logic [REG_DW-1:0]             w_push_data;
    logic [DEPTH-1:0]              w_ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  w_ent_addr;
    logic [DEPTH-1:0][REG_DW-1:0]  w_ent_data;

    // Ready depends only on valids, grant state and drain; never on another ready.
    assign w_pop       = !w_empty && !wb_hold;
    assign w_space     = !w_full || w_pop;
    assign w_grant_a   = a_valid && (!l_valid || (r_last == PORT_L));
    assign w_grant_l   = l_valid && (!a_valid || (r_last == PORT_A));
    assign a_ready     = resetn && w_grant_a && w_space;
    assign l_ready     = resetn && w_grant_l && w_space;
    assign w_push_addr = a_ready ? a_addr : l_addr;
    assign w_push_data = a_ready ? a_data : l_data;
    assign w_push      = (a_ready || l_ready) && is_live_reg(w_push_addr);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_addr      (w_push_addr),
        .i_data      (w_push_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_ent_valid (w_ent_valid),
        .o_ent_addr  (w_ent_addr),
        .o_ent_data  (w_ent_data)
    );

    // Round-robin state advances only on an actual acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= PORT_L;
        end else if (a_ready) begin
            r_last <= PORT_A;
        end else if (l_ready) begin
            r_last <= PORT_L;
        end else begin
            r_last <= r_last;
        end
    end

    // Register-file port mirrors the head entry whenever it drains.
    always_comb begin
        rf_we = w_pop;
        if (w_pop) begin
            rf_waddr = w_ent_addr[0];
            rf_wdata = w_ent_data[0];
        end else begin
            rf_waddr = REG_ZERO;
            rf_wdata = 32'd0;
        end
    end

    // Scan oldest to youngest so the last match leaves the youngest value.
    always_comb begin
        q_hit1  = 1'b0;
        q_data1 = 32'd0;
        q_hit2  = 1'b0;
        q_data2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && is_live_reg(q_raddr1) && (w_ent_addr[i] == q_raddr1)) begin
                q_hit1  = 1'b1;
                q_data1 = w_ent_data[i];
            end else begin
                q_hit1  = q_hit1;
                q_data1 = q_data1;
            end
            if (w_ent_valid[i] && is_live_reg(q_raddr2) && (w_ent_addr[i] == q_raddr2)) begin
                q_hit2  = 1'b1;
                q_data2 = w_ent_data[i];
            end else begin
                q_hit2  = q_hit2;
                q_data2 = q_data2;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Bench for reg_wb_arb: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_reg_wb_arb;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_valid, a_ready, l_valid, l_ready, wb_hold, rf_we, q_hit1, q_hit2;
    logic [4:0]  a_addr, l_addr, rf_waddr, q_raddr1, q_raddr2;
    logic [31:0] a_data, l_data, rf_wdata, q_data1, q_data2;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  mq_addr[$];
    logic [31:0] mq_data[$];
    bit          m_last_l;
    int          exp_grant;
    bit          exp_pop;

    always #5 clk = ~clk;

    reg_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
        .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
        .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_addr.delete();
        mq_data.delete();
        m_last_l  = 1'b1;
        exp_grant = 0;
        exp_pop   = 1'b0;
    endtask

    function automatic void lookup(input logic [4:0] qa, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (qa != 5'd0) begin
            for (int i = mq_addr.size() - 1; i >= 0; i--) begin
                if (mq_addr[i] == qa) begin
                    h = 1'b1;
                    d = mq_data[i];
                    break;
                end
            end
        end
    endfunction

    // Compare every DUT output against the model on the falling edge.
    task automatic settle();
        logic        e_h1, e_h2;
        logic [31:0] e_d1, e_d2, e_waddr, e_wdata;
        @(negedge clk);
        if (!resetn) begin
            model_reset();
            e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = 32'd0; e_d2 = 32'd0;
            e_waddr = 32'd0; e_wdata = 32'd0;
        end else begin
            exp_pop = (mq_addr.size() > 0) && !wb_hold;
            if (a_valid && l_valid) exp_grant = m_last_l ? 1 : 2;
            else if (a_valid)       exp_grant = 1;
            else if (l_valid)       exp_grant = 2;
            else                    exp_grant = 0;
            if (!(mq_addr.size() < DEPTH || exp_pop)) exp_grant = 0;
            e_waddr = exp_pop ? 32'(mq_addr[0]) : 32'd0;
            e_wdata = exp_pop ? mq_data[0] : 32'd0;
            lookup(q_raddr1, e_h1, e_d1);
            lookup(q_raddr2, e_h2, e_d2);
        end
        check("rf_we",    32'(rf_we),   32'(exp_pop));
        check("rf_waddr", 32'(rf_waddr), e_waddr);
        check("rf_wdata", rf_wdata,      e_wdata);
        check("a_ready",  32'(a_ready), 32'(exp_grant == 1));
        check("l_ready",  32'(l_ready), 32'(exp_grant == 2));
        check("q_hit1",   32'(q_hit1),  32'(e_h1));
        check("q_data1",  q_data1,       e_d1);
        check("q_hit2",   32'(q_hit2),  32'(e_h2));
        check("q_data2",  q_data2,       e_d2);
    endtask

    task automatic advance();
        @(posedge clk);
        if (resetn) begin
            if (exp_pop) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (exp_grant == 1) begin
                m_last_l = 1'b0;
                if (a_addr != 5'd0) begin mq_addr.push_back(a_addr); mq_data.push_back(a_data); end
            end else if (exp_grant == 2) begin
                m_last_l = 1'b1;
                if (l_addr != 5'd0) begin mq_addr.push_back(l_addr); mq_data.push_back(l_data); end
            end
        end
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; l_valid = 1'b0; a_addr = 5'd0; l_addr = 5'd0;
        a_data = 32'd0; l_data = 32'd0; wb_hold = 1'b0; q_raddr1 = 5'd0; q_raddr2 = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        settle();
        advance();
        resetn = 1'b1;
    endtask

    initial begin
        int seq [4] = '{1, 2, 1, 2};
        model_reset();
        do_reset();

        // Single request, one-cycle latency to the register file.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        settle(); check("lit_first_ready", 32'(a_ready), 32'd1); advance();
        idle();
        settle();
        check("lit_lat_we", 32'(rf_we), 32'd1);
        check("lit_lat_addr", 32'(rf_waddr), 32'd3);
        check("lit_lat_data", rf_wdata, 32'h11);
        advance();

        // Both ports valid every cycle: grants alternate starting with A.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
        l_valid = 1'b1; l_addr = 5'd2; l_data = 32'hB2;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("lit_rr_a_ready", 32'(a_ready), 32'(k % 2 == 0));
            if (k > 0) check("lit_rr_waddr", 32'(rf_waddr), 32'(seq[k-1]));
            advance();
        end

        // Fill under hold: fifth request stalls until the buffer drains.
        do_reset();
        wb_hold = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_addr = 5'(i + 1); a_data = 32'(100 + i);
            settle();
            check("lit_fill_ready", 32'(a_ready), 32'(i < 4));
            if (i < 4) advance();
        end
        check("lit_fill_we", 32'(rf_we), 32'd0);
        advance();
        a_valid = 1'b0; wb_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("lit_drain_addr", 32'(rf_waddr), 32'(k + 1));
            check("lit_drain_data", rf_wdata, 32'(100 + k));
            advance();
        end
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd104;
        settle(); check("lit_fifth_ready", 32'(a_ready), 32'd1); advance();
        a_valid = 1'b0;
        settle(); check("lit_fifth_addr", 32'(rf_waddr), 32'd5); advance();

        // Same register twice: youngest value wins, zero query never hits.
        do_reset();
        wb_hold = 1'b1; a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA;
        settle(); advance();
        a_data = 32'hB;
        settle(); advance();
        a_valid = 1'b0; q_raddr1 = 5'd7; q_raddr2 = 5'd0;
        settle();
        check("lit_q_hit1", 32'(q_hit1), 32'd1);
        check("lit_q_data1", q_data1, 32'hB);
        check("lit_q_hit2", 32'(q_hit2), 32'd0);
        advance();

        // Write to r0: accepted, never written, never visible.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
        settle(); check("lit_r0_ready", 32'(a_ready), 32'd1); advance();
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle(); check("lit_r0_we", 32'(rf_we), 32'd0); advance();
        end

        // Reset in the middle of draining a full buffer.
        do_reset();
        wb_hold = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 5'(i + 9); a_data = 32'(i);
            settle(); advance();
        end
        a_valid = 1'b0; wb_hold = 1'b0;
        settle(); check("lit_mid_we", 32'(rf_we), 32'd1); advance();
        a_valid = 1'b1; l_valid = 1'b1; a_addr = 5'd9; l_addr = 5'd10;
        resetn = 1'b0;
        #1;
        check("lit_rst_we", 32'(rf_we), 32'd0);
        check("lit_rst_waddr", 32'(rf_waddr), 32'd0);
        check("lit_rst_a_ready", 32'(a_ready), 32'd0);
        model_reset();
        settle(); advance();
        resetn = 1'b1;
        settle();
        check("lit_post_a_ready", 32'(a_ready), 32'd1);
        check("lit_post_l_ready", 32'(l_ready), 32'd0);
        check("lit_post_we", 32'(rf_we), 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            resetn   = ($urandom_range(0, 149) != 0);
            a_valid  = ($urandom_range(0, 99) < 60);
            l_valid  = ($urandom_range(0, 99) < 60);
            a_addr   = 5'($urandom_range(0, 7));
            l_addr   = 5'($urandom_range(0, 7));
            a_data   = $urandom();
            l_data   = $urandom();
            wb_hold  = ($urandom_range(0, 99) < 35);
            q_raddr1 = 5'($urandom_range(0, 7));
            q_raddr2 = 5'($urandom_range(0, 7));
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports a_valid/a_ready  input/output  1/1  ALU-pipe write request handshake.
REQ-005 SHALL have ports a_addr/a_data  input  5/32  ALU-pipe destination register and value.
REQ-006 SHALL have ports l_valid/l_ready  input/output  1/1  long-latency (mul/div/load) write request handshake.
REQ-007 SHALL have ports l_addr/l_data  input  5/32  long-latency destination register and value.
REQ-008 SHALL have port wb_hold  input  1  when high, no entry drains to the register file this cycle.
REQ-009 SHALL have ports rf_we/rf_waddr/rf_wdata  output  1/5/32  register-file write port.
REQ-010 SHALL have ports q_raddr1/q_raddr2  input  5/5  hazard query addresses.
REQ-011 SHALL have ports q_hit1/q_hit2  output  1/1  query address pending in buffer.
REQ-012 SHALL have ports q_data1/q_data2  output  32/32  youngest pending value for the query address.

Function
REQ-013 SHALL accept a request on a port when valid && ready are both high at a rising edge; at most one request accepted per cycle.
REQ-014 SHALL grant by round-robin when both ports valid: grant the port not granted last; single valid port always granted if space.
REQ-015 SHALL drive x_ready high only for the granted port and only if buffer not full or an entry drains this same cycle.
REQ-016 SHALL keep x_ready independent of its own x_valid-to-ready combinational loop beyond the grant decision (no ready-depends-on-ready paths).
REQ-017 SHALL accept but not enqueue a request with addr 5'd0; it consumes the grant and updates round-robin state.
REQ-018 SHALL drain the buffer head to rf_* each cycle in which buffer non-empty and wb_hold low: rf_we=1, rf_waddr/rf_wdata = head fields.
REQ-019 SHALL present rf_we=0 while buffer empty or wb_hold high; rf_waddr/rf_wdata then 0.
REQ-020 SHALL give latency of exactly one cycle from acceptance (edge N) to rf_we (cycle after edge N) when buffer was empty and wb_hold low.
REQ-021 SHALL preserve acceptance order in write order (FIFO), including writes to the same register.
REQ-022 SHALL support simultaneous enqueue and dequeue when full; occupancy unchanged.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-024 SHALL compute q_hitN combinationally: 1 if any valid entry (including head being written this cycle) has addr == q_raddrN and q_raddrN != 0.
REQ-025 SHALL return in q_dataN the data of the youngest matching entry; 0 when no hit.

Reset
REQ-026 SHALL on resetn low, immediately clear occupancy, both pointers and round-robin state (last grant = L, so A wins first tie).
REQ-027 SHALL during reset drive a_ready=l_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, q_hit1/2=0, q_data1/2=0.
REQ-028 SHALL discard buffered entries on reset asserted mid-operation; no partial write emitted.
REQ-029 SHALL leave buffer data storage unreset; only valid-tracking state is reset.

Structure
REQ-030 SHALL place register-address width (5), data width (32) and the zero-register constant in the shared CPU package.
REQ-031 SHALL implement the buffer as one sub-module wb_fifo (push/pop/full/empty plus per-entry addr/data/valid visibility for queries).

Verification
REQ-032 Reset then a_valid=1 a_addr=3 a_data=32'h11 one cycle -> next cycle rf_we=1 rf_waddr=3 rf_wdata=32'h11.
REQ-033 Both valid every cycle, addrs A=1 L=2 -> grants alternate A,L,A,L; rf_waddr sequence 1,2,1,2.
REQ-034 wb_hold=1, push 5 entries with DEPTH=4 -> 4 accepted, fifth sees ready=0; release hold -> 4 writes in order, then fifth accepted.
REQ-035 Push r7=32'hA then r7=32'hB under hold, q_raddr1=7 -> q_hit1=1 q_data1=32'hB; q_raddr2=0 -> q_hit2=0.
REQ-036 Push addr 0 data 32'hFF -> accepted (ready=1), rf_we never asserted, q_hit never set.
REQ-037 Full buffer, assert resetn low mid-drain -> rf_we=0 immediately, after release buffer empty and first tie granted to A.
